ws2811_serializer: RTL
======================

# ws2811_serializer

- Sits directly downstream of the per-pixel colour controller and drives the LED string.
- Presents `ledindex` to the controller and latches the controller's 8-bit `red`/`green`/`blue` once per pixel.
- Shifts each pixel out as 24 NRZ pulse-width-coded bits on a single data line, then holds the line low for a latch/reset gap.
- Repeats frames continuously while enabled, prefetching the next pixel's colour while the current pixel is on the wire.

## Interface
Parameters:
- `NUM_LEDS`, 50: pixels per frame, 1..255.
- `T0H`, 20: high time of a 0 bit, in clocks.
- `T1H`, 40: high time of a 1 bit, in clocks; must satisfy T0H < T1H < TBIT.
- `TBIT`, 63: total bit period, in clocks (1.25 µs at 50 MHz).
- `RESET_CYCLES`, 3000: low gap after a frame, in clocks; must be ≥ 64.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low (already decided).
- `enable`  in  1  permits starting a new frame.
- `red`  in  8  controller output for the pixel at `ledindex`.
- `green`  in  8  controller output for the pixel at `ledindex`.
- `blue`  in  8  controller output for the pixel at `ledindex`.
- `ledindex`  out  8  pixel the controller must compute next.
- `dout`  out  1  serial data to the string.
- `busy`  out  1  high while in SEND.
- `frame_done`  out  1  one-cycle pulse on entering GAP after the last pixel.

## Operation
- States: GAP, IDLE, SEND. Counters:
  - `gapcnt`, 0..RESET_CYCLES-1.
  - `bitcnt`, 0..TBIT-1.
  - `bitidx`, 0..23.
  - `pixcnt`, 0..NUM_LEDS-1.
- 24-bit shift register. Bits go MSB first, default order {red, green, blue} (native WS2811).
- Reset values:
  - state GAP; `gapcnt`=0.
  - `dout`=0, `busy`=0, `frame_done`=0.
  - `ledindex`=0; shift register=0.
- GAP: `dout`=0; `gapcnt` increments. At `gapcnt`==RESET_CYCLES-1:
  - if `enable`=1: do LOAD, go to SEND.
  - else: go to IDLE.
- IDLE: `dout`=0. First cycle with `enable`=1: do LOAD, go to SEND.
- LOAD (an action performed on a transition, not a state):
  - shift register <= colour bus.
  - `ledindex` <= next index; next index wraps to 0 after NUM_LEDS-1.
  - `pixcnt` <= pixel number being loaded; `bitcnt`, `bitidx` <= 0.
- SEND: bit value b = shift register MSB.
  - `dout`=1 while `bitcnt` < (b ? T1H : T0H), else 0.
  - At `bitcnt`==TBIT-1: `bitcnt` <= 0, shift left by one, `bitidx` increments.
  - At `bitcnt`==TBIT-1 and `bitidx`==23:
    - if `pixcnt` < NUM_LEDS-1: LOAD the next pixel and stay in SEND. No gap between pixels.
    - else: go to GAP with `gapcnt` <= 0 and pulse `frame_done`.
- `enable` is only sampled at frame start. Deasserting it mid-frame never truncates the frame.
- `ledindex` is constant between LOAD events:
  - ≥ 24·TBIT clocks within a frame;
  - ≥ RESET_CYCLES clocks before a frame start.
- The controller's 32-cycle calculation therefore always completes before the latch. This is the reason for the RESET_CYCLES ≥ 64 rule.
- After the final LOAD of a frame, `ledindex`=0, so pixel 0 is precomputed during GAP.
- NUM_LEDS=1: `ledindex` stays 0 throughout.

## Timing
- `dout`, `busy`, `frame_done` and `ledindex` are flop outputs, decoded from next-state values. `dout` is glitch-free and has no combinational path from the inputs.
- The colour bus is latched on the clock edge that performs LOAD. The first high cycle of `dout` is the cycle following that edge.
- Each bit lasts exactly TBIT cycles:
  - 0 bit: T0H high cycles.
  - 1 bit: T1H high cycles.
- Frame length = NUM_LEDS·24·TBIT cycles, then RESET_CYCLES low cycles.
- Back-to-back frames with `enable` held high have period NUM_LEDS·24·TBIT + RESET_CYCLES.
- `frame_done` is high for exactly the first GAP cycle.
- `rst_n` asserted mid-frame:
  - `dout` goes to 0 immediately (asynchronous) and the bit is truncated.
  - After release, a full RESET_CYCLES gap occurs before any data, so the string latches cleanly.

## Configuration
- `WS2811_GRB_ORDER_EN`
  - Defined: the shift register loads {green, red, blue}, for WS2812-type strings.
  - Undefined: loads {red, green, blue}.
- Timing and all other behaviour are identical in both builds.

## Test plan
Bench parameters: NUM_LEDS=3, T0H=2, T1H=4, TBIT=6, RESET_CYCLES=64.
- Reset, `enable`=0: `dout`=0, `ledindex`=0, `busy`=0 at all times; no `frame_done` after 64 cycles (IDLE).
- `enable`=1 with the colour bus driven {0xA5,0x0F,0x81}:
  - first pixel's 24 bit periods carry high widths 4,2,4,2,2,4,2,4 for red;
  - then green and blue follow MSB first;
  - each bit period is exactly 6 cycles.
- Colour model keyed by `ledindex`:
  - `ledindex` steps 1,2,0 at the pixel boundaries;
  - pixels on the wire match indices 0,1,2;
  - `frame_done` pulses once, at cycle 3·24·6 after the first rising edge;
  - `dout` then stays low for 64 cycles.
- `enable` dropped during pixel 1: frame completes all 3 pixels, then the block enters IDLE. Re-asserting `enable` starts the next frame on the following cycle.
- `rst_n` pulsed low mid-bit:
  - `dout`=0 within the same cycle;
  - after release, 64 low cycles precede the first rising edge;
  - `ledindex`=0.
- Build with `WS2811_GRB_ORDER_EN` and colour {0xFF,0x00,0x00}: first 8 bits are 0s and bits 8–15 are 1s.

Source files
------------

// File: rtl/ws2811_serializer.sv
// WS2811 NRZ serializer: latches one pixel colour per LOAD and shifts 24 pulse-width-coded bits.
// Define WS2811_GRB_ORDER_EN to load {green, red, blue} for WS2812-type strings.
`timescale 1ns/1ps
module ws2811_serializer #(
    parameter int NUM_LEDS     = 50,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int TBIT         = 63,
    parameter int RESET_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] ledindex,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int BW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam int GW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [BW-1:0] TBIT_M1 = BW'(TBIT - 1);
    localparam logic [BW-1:0] T0H_W   = BW'(T0H);
    localparam logic [BW-1:0] T1H_W   = BW'(T1H);
    localparam logic [GW-1:0] GAP_M1  = GW'(RESET_CYCLES - 1);
    localparam logic [7:0]    LAST    = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        GAP,
        IDLE,
        SEND
    } state_t;

    state_t        state;
    logic [GW-1:0] gapcnt;
    logic [BW-1:0] bitcnt;
    logic [4:0]    bitidx;
    logic [7:0]    pixcnt;
    logic [23:0]   sreg;

    logic [23:0]   color;
    logic [7:0]    next_idx;
    logic [BW-1:0] bitcnt_inc;
    logic [BW-1:0] thr;
    logic          bit_last;
    logic          pix_last;
    logic          more_pix;
    logic          hi_nx;

`ifdef WS2811_GRB_ORDER_EN
    assign color = {green, red, blue};
`else
    assign color = {red, green, blue};
`endif

    assign next_idx   = (ledindex == LAST) ? 8'd0 : ledindex + 8'd1;
    assign bitcnt_inc = bitcnt + 1'b1;
    assign thr        = sreg[23] ? T1H_W : T0H_W;
    assign bit_last   = (bitcnt == TBIT_M1);
    assign pix_last   = (bitidx == 5'd23);
    assign more_pix   = (pixcnt < LAST);
    // dout is registered from the bit counter value the next cycle will hold
    assign hi_nx      = (bitcnt_inc < thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP;
            gapcnt     <= '0;
            bitcnt     <= '0;
            bitidx     <= '0;
            pixcnt     <= '0;
            sreg       <= '0;
            ledindex   <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                GAP: begin
                    dout <= 1'b0;
                    if (gapcnt == GAP_M1) begin
                        gapcnt <= '0;
                        if (enable) begin
                            sreg     <= color;
                            ledindex <= next_idx;
                            pixcnt   <= ledindex;
                            bitcnt   <= '0;
                            bitidx   <= '0;
                            dout     <= 1'b1;
                            busy     <= 1'b1;
                            state    <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gapcnt <= gapcnt + 1'b1;
                    end
                end
                IDLE: begin
                    dout <= 1'b0;
                    if (enable) begin
                        sreg     <= color;
                        ledindex <= next_idx;
                        pixcnt   <= ledindex;
                        bitcnt   <= '0;
                        bitidx   <= '0;
                        dout     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_last) begin
                        bitcnt <= '0;
                        if (pix_last && more_pix) begin
                            sreg     <= color;
                            ledindex <= next_idx;
                            pixcnt   <= ledindex;
                            bitidx   <= '0;
                            dout     <= 1'b1;
                        end else if (pix_last) begin
                            gapcnt     <= '0;
                            dout       <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= GAP;
                        end else begin
                            sreg   <= {sreg[22:0], 1'b0};
                            bitidx <= bitidx + 5'd1;
                            dout   <= 1'b1;
                        end
                    end else begin
                        bitcnt <= bitcnt_inc;
                        dout   <= hi_nx;
                    end
                end
                default: begin
                    state <= GAP;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
